regbank_trace_encoder: RTL and testbench
========================================

REGBANK_TRACE_ENCODER -- requirements
Module: regbank_trace_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset is synchronous and active-low.
REQ-004 Port: RegWriteW  input  1  write-back write enable.
REQ-005 Port: WA3W  input  32  write-back physical register select, expected one-hot (bit i = physical register i).
REQ-006 Port: WD3W  input  32  write-back data.
REQ-007 Port: trace_en  input  1  capture enable; write-backs are ignored while low.
REQ-008 Port: clear_stats  input  1  clears the overflow flag and the drop counter.
REQ-009 Port: trace_valid  output  1  the head entry is valid.
REQ-010 Port: trace_ready  input  1  consumer accepts the head entry when trace_valid is also high.
REQ-011 Port: trace_idx  output  5  physical register index of the head entry.
REQ-012 Port: trace_mode  output  3  bank class of the head entry.
REQ-013 Port: trace_areg  output  4  architectural register number of the head entry.
REQ-014 Port: trace_data  output  32  captured write data of the head entry.
REQ-015 Port: trace_err  output  1  the head entry came from a non-one-hot select.
REQ-016 Port: overflow  output  1  sticky flag; set when any capture has been dropped.
REQ-017 Port: drop_count  output  8  saturating count of dropped captures.

Function
REQ-018 A capture request exists in a cycle when RegWriteW and trace_en are both high.
REQ-019 Index encode: trace_idx is the position of the single set bit of WA3W.
REQ-020 Bank map for physical index to {mode, areg}:
  - 0-7 -> {SHARED=0, 0-7}
  - 8-12 -> {USR=1, 8-12}
  - 13-14 -> {USR, 13-14}
  - 15 -> {SHARED, 15}
  - 16-17 -> {SVC=4, 13-14}
  - 18-19 -> {ABT=5, 13-14}
  - 20-21 -> {UND=6, 13-14}
  - 22-23 -> {IRQ=3, 13-14}
  - 24-30 -> {FIQ=2, 8-14}
  - 31 -> {RZ=7, 15}
REQ-021 Non-one-hot WA3W (zero set bits, or two or more): the entry is captured with err=1; idx, mode and areg are derived from the lowest set bit, or are 0 when WA3W is zero.
REQ-022 Capture latency: a request in cycle N appears in the FIFO; if the FIFO was empty, trace_valid is high in cycle N+1.
REQ-023 The FIFO is in-order with DEPTH entries; all trace_* outputs are driven from registered head-entry storage.
REQ-024 Pop occurs when trace_valid and trace_ready are both high; a pop while empty has no effect.
REQ-025 Push is accepted when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs in the same cycle.
REQ-026 Push rejected because the FIFO is full with no pop:
  - the entry is dropped;
  - overflow is set to 1;
  - drop_count increments, saturating at 255.
REQ-027 Simultaneous push and pop: occupancy is unchanged; order is preserved; a push into an empty FIFO with trace_ready high is not popped in the same cycle.
REQ-028 Read and write pointers wrap modulo DEPTH; occupancy is held in a separate counter of width log2(DEPTH)+1.
REQ-029 clear_stats coinciding with a drop: clear wins; overflow reads 0 and drop_count reads 0 in the next cycle.
REQ-030 trace_en falling does not flush the FIFO; stored entries still drain.
REQ-031 Stability rule: while trace_valid is high and trace_ready is low, all trace_* outputs hold their values.

Reset
REQ-032 When reset_n is low at a clock edge:
  - FIFO is emptied;
  - pointers and occupancy are zeroed;
  - trace_valid, overflow and drop_count are 0.
REQ-033 Reset mid-operation discards all stored entries and any same-cycle capture; trace_* data outputs read 0 after reset.
REQ-034 Capture resumes on the first cycle in which reset_n is high.

Structure
REQ-035 The bank-class enum (SHARED, USR, FIQ, IRQ, SVC, ABT, UND, RZ) and the physical-index constants for R16/R18/R20/R22/R24/Rz belong in the shared register-bank package.
REQ-036 A combinational sub-module, regbank_index_encode, holds the logic WA3W -> {idx, mode, areg, err}.
REQ-037 The FIFO and the statistics logic reside in the top module.

Verification
REQ-038 Mapping sweep: trace_en=1, trace_ready=1, single writes with WA3W=1<<i for i=0..31 -> each trace entry matches REQ-020, e.g. i=21 -> {idx 21, UND, 14}, i=31 -> {RZ, 15}.
REQ-039 Error case: WA3W=32'h00000000 -> entry {err=1, idx=0}; WA3W=32'h00030000 -> entry {err=1, idx=16, SVC, 13}.
REQ-040 Overflow: DEPTH=4, trace_ready=0, 6 consecutive writes -> 4 entries stored, overflow=1, drop_count=2; then a pop drains data in original order.
REQ-041 Full plus simultaneous pop and push: FIFO full, trace_ready=1, one write -> no drop, occupancy stays 4, drop_count unchanged.
REQ-042 Reset mid-stream: 3 entries queued, reset_n=0 for one cycle -> next cycle trace_valid=0 and drop_count=0; a following write appears at N+1.
REQ-043 Saturation and clear: 300 drops -> drop_count=255; clear_stats pulse -> overflow=0, drop_count=0.

Source files
------------

// File: rtl/regbank_trace_encoder_pkg.sv
// Shared register-bank definitions: bank classes, banked physical indices,
// and the trace FIFO entry layout.
package regbank_trace_encoder_pkg;

  typedef enum logic [2:0] {
    BANK_SHARED = 3'd0,
    BANK_USR    = 3'd1,
    BANK_FIQ    = 3'd2,
    BANK_IRQ    = 3'd3,
    BANK_SVC    = 3'd4,
    BANK_ABT    = 3'd5,
    BANK_UND    = 3'd6,
    BANK_RZ     = 3'd7
  } bank_mode_e;

  localparam logic [4:0] R16_IDX = 5'd16;
  localparam logic [4:0] R18_IDX = 5'd18;
  localparam logic [4:0] R20_IDX = 5'd20;
  localparam logic [4:0] R22_IDX = 5'd22;
  localparam logic [4:0] R24_IDX = 5'd24;
  localparam logic [4:0] RZ_IDX  = 5'd31;

  typedef struct packed {
    logic [4:0]  idx;
    bank_mode_e  mode;
    logic [3:0]  areg;
    logic [31:0] data;
    logic        err;
  } trace_entry_t;

endpackage

// File: rtl/regbank_index_encode.sv
// One-hot write-back select -> physical index, bank class and architectural
// register; non-one-hot selects decode from the lowest set bit and flag err.
module regbank_index_encode
  import regbank_trace_encoder_pkg::*;
(
  input  logic [31:0] WA3W,
  output logic [4:0]  idx,
  output bank_mode_e  mode,
  output logic [3:0]  areg,
  output logic        err
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (WA3W[i] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end

    err = (WA3W == '0) || ((WA3W & (WA3W - 32'd1)) != '0);

    // Banked pairs 16..23 all map onto R13/R14; the low index bit picks which.
    mode = BANK_SHARED;
    areg = idx[3:0];
    if (idx >= RZ_IDX) begin
      mode = BANK_RZ;
      areg = 4'd15;
    end else if (idx >= R24_IDX) begin
      mode = BANK_FIQ;
      areg = 4'(idx - 5'd16);
    end else if (idx >= R22_IDX) begin
      mode = BANK_IRQ;
      areg = 4'd13 + 4'(idx[0]);
    end else if (idx >= R20_IDX) begin
      mode = BANK_UND;
      areg = 4'd13 + 4'(idx[0]);
    end else if (idx >= R18_IDX) begin
      mode = BANK_ABT;
      areg = 4'd13 + 4'(idx[0]);
    end else if (idx >= R16_IDX) begin
      mode = BANK_SVC;
      areg = 4'd13 + 4'(idx[0]);
    end else if (idx >= 5'd8 && idx <= 5'd14) begin
      mode = BANK_USR;
    end
  end

endmodule

// File: rtl/regbank_trace_encoder.sv
// Captures register write-backs into an in-order trace FIFO and keeps
// overflow / drop statistics for captures lost to a full FIFO.
module regbank_trace_encoder
  import regbank_trace_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWriteW,
  input  logic [31:0] WA3W,
  input  logic [31:0] WD3W,
  input  logic        trace_en,
  input  logic        clear_stats,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [4:0]  trace_idx,
  output logic [2:0]  trace_mode,
  output logic [3:0]  trace_areg,
  output logic [31:0] trace_data,
  output logic        trace_err,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [4:0]  enc_idx;
  bank_mode_e  enc_mode;
  logic [3:0]  enc_areg;
  logic        enc_err;
  logic        push_req, push_ok, pop, drop;
  trace_entry_t head;

  regbank_index_encode u_encode (
    .WA3W (WA3W),
    .idx  (enc_idx),
    .mode (enc_mode),
    .areg (enc_areg),
    .err  (enc_err)
  );

  // Pop is judged on registered occupancy, so a fresh push is never popped
  // in the cycle it is written.
  assign trace_valid = (count != '0);
  assign pop         = trace_valid && trace_ready;
  assign push_req    = RegWriteW && trace_en;
  assign push_ok     = push_req && ((count < FULL_CNT) || pop);
  assign drop        = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{idx: enc_idx, mode: enc_mode, areg: enc_areg,
                         data: WD3W, err: enc_err};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 8'd1;
    end
  end

  assign head       = mem[rd_ptr];
  assign trace_idx  = head.idx;
  assign trace_mode = head.mode;
  assign trace_areg = head.areg;
  assign trace_data = head.data;
  assign trace_err  = head.err;

endmodule

// File: tb/tb_regbank_trace_encoder.sv
// Randomized and directed bench for the write-back trace encoder against a
// queue-based reference model.
module tb_regbank_trace_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, RegWriteW, trace_en, clear_stats, trace_ready;
  logic [31:0] WA3W, WD3W;
  logic        trace_valid, trace_err, overflow;
  logic [4:0]  trace_idx;
  logic [2:0]  trace_mode;
  logic [3:0]  trace_areg;
  logic [31:0] trace_data;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    int          mode;
    int          areg;
    logic [31:0] data;
    int          err;
  } m_entry_t;

  m_entry_t mq[$];
  int       m_ov = 0;
  int       m_dc = 0;

  always #5 clk = ~clk;

  regbank_trace_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .RegWriteW   (RegWriteW),
    .WA3W        (WA3W),
    .WD3W        (WD3W),
    .trace_en    (trace_en),
    .clear_stats (clear_stats),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_idx   (trace_idx),
    .trace_mode  (trace_mode),
    .trace_areg  (trace_areg),
    .trace_data  (trace_data),
    .trace_err   (trace_err),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  // Bank table straight from the register map: class codes and arch numbers.
  function automatic m_entry_t model_entry(input logic [31:0] wa, input logic [31:0] wd);
    m_entry_t e;
    int p = 0;
    for (int i = 31; i >= 0; i--) if (wa[i]) p = i;
    e.idx  = p;
    e.data = wd;
    e.err  = ($countones(wa) != 1) ? 1 : 0;
    if (p <= 7)       begin e.mode = 0; e.areg = p; end
    else if (p <= 14) begin e.mode = 1; e.areg = p; end
    else if (p == 15) begin e.mode = 0; e.areg = 15; end
    else if (p <= 23) begin
      int cls[4] = '{4, 5, 6, 3};
      e.mode = cls[(p - 16) / 2];
      e.areg = 13 + (p % 2);
    end
    else if (p <= 30) begin e.mode = 2; e.areg = p - 16; end
    else              begin e.mode = 7; e.areg = 15; end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs, then advance the model with the inputs the next edge samples.
  always @(negedge clk) begin
    bit pop, req, accept;
    chk("valid", int'(trace_valid), (mq.size() != 0) ? 1 : 0);
    chk("overflow", int'(overflow), m_ov);
    chk("drop_count", int'(drop_count), m_dc);
    if (mq.size() != 0) begin
      checks++;
      if (trace_idx !== 5'(mq[0].idx) || trace_mode !== 3'(mq[0].mode) ||
          trace_areg !== 4'(mq[0].areg) || trace_data !== mq[0].data ||
          trace_err !== 1'(mq[0].err)) begin
        errors++;
        $display("FAIL head: got idx %0d mode %0d areg %0d data %h err %0d expected idx %0d mode %0d areg %0d data %h err %0d at %0t",
                 trace_idx, trace_mode, trace_areg, trace_data, trace_err,
                 mq[0].idx, mq[0].mode, mq[0].areg, mq[0].data, mq[0].err, $time);
      end
    end
    if (reset_n !== 1'b1) begin
      mq.delete();
      m_ov = 0;
      m_dc = 0;
    end else begin
      pop    = (mq.size() != 0) && trace_ready;
      req    = RegWriteW && trace_en;
      accept = req && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back(model_entry(WA3W, WD3W));
      if (clear_stats) begin
        m_ov = 0;
        m_dc = 0;
      end else if (req && !accept) begin
        m_ov = 1;
        if (m_dc < 255) m_dc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] wa);
    RegWriteW = 1'b1;
    WA3W      = wa;
    WD3W      = $urandom;
    tick();
    RegWriteW = 1'b0;
  endtask

  task automatic drain();
    trace_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    m_entry_t e;
    reset_n = 1'b0; RegWriteW = 1'b0; WA3W = '0; WD3W = '0;
    trace_en = 1'b1; clear_stats = 1'b0; trace_ready = 1'b1;

    e = model_entry(32'h0020_0000, 32'h0);
    chk("model_r21_idx", e.idx, 21); chk("model_r21_mode", e.mode, 6); chk("model_r21_areg", e.areg, 14);
    e = model_entry(32'h8000_0000, 32'h0);
    chk("model_rz_mode", e.mode, 7); chk("model_rz_areg", e.areg, 15);
    e = model_entry(32'h0003_0000, 32'h0);
    chk("model_multi_err", e.err, 1); chk("model_multi_idx", e.idx, 16); chk("model_multi_areg", e.areg, 13);

    tick(); tick();
    chk("rst_valid", int'(trace_valid), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_data", int'(trace_data), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      wr(32'h1 << i);
      if (i == 21) begin
        chk("sweep21_valid", int'(trace_valid), 1);
        chk("sweep21_idx", int'(trace_idx), 21);
        chk("sweep21_mode", int'(trace_mode), 6);
        chk("sweep21_areg", int'(trace_areg), 14);
      end
      if (i == 31) begin
        chk("sweep31_mode", int'(trace_mode), 7);
        chk("sweep31_areg", int'(trace_areg), 15);
      end
    end
    tick();

    wr(32'h0);
    chk("err0_err", int'(trace_err), 1);
    chk("err0_idx", int'(trace_idx), 0);
    wr(32'h0003_0000);
    chk("errm_err", int'(trace_err), 1);
    chk("errm_idx", int'(trace_idx), 16);
    chk("errm_mode", int'(trace_mode), 4);
    chk("errm_areg", int'(trace_areg), 13);
    drain();

    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(32'h1 << (i + 3));
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drops", int'(drop_count), 2);
    chk("ovf_head", int'(trace_idx), 3);
    drain();

    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(32'h1 << (i + 24));
    trace_ready = 1'b1;
    wr(32'h0000_0100);
    chk("fullpop_drops", int'(drop_count), 2);
    trace_ready = 1'b0;
    wr(32'h0000_0200);
    chk("fullpop_still_full", int'(drop_count), 3);
    drain();

    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h1 << (i + 16));
    reset_n = 1'b0;
    wr(32'h0000_0001);
    reset_n = 1'b1;
    chk("midrst_valid", int'(trace_valid), 0);
    chk("midrst_drop", int'(drop_count), 0);
    chk("midrst_idx", int'(trace_idx), 0);
    wr(32'h0000_0004);
    chk("midrst_resume", int'(trace_valid), 1);
    chk("midrst_resume_idx", int'(trace_idx), 2);
    drain();

    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 300; i++) wr(32'h1 << (i % 32));
    chk("sat_drops", int'(drop_count), 255);
    chk("sat_flag", int'(overflow), 1);
    clear_stats = 1'b1;
    wr(32'h0000_0002);
    clear_stats = 1'b0;
    chk("clear_flag", int'(overflow), 0);
    chk("clear_drops", int'(drop_count), 0);
    drain();

    for (int n = 0; n < 3000; n++) begin
      int sel = $urandom_range(0, 9);
      reset_n     = ($urandom_range(0, 199) != 0);
      RegWriteW   = ($urandom_range(0, 3) != 0);
      trace_en    = ($urandom_range(0, 7) != 0);
      trace_ready = ($urandom_range(0, 2) != 0);
      clear_stats = ($urandom_range(0, 49) == 0);
      WD3W        = $urandom;
      if (sel == 0)      WA3W = '0;
      else if (sel == 1) WA3W = $urandom;
      else               WA3W = 32'h1 << $urandom_range(0, 31);
      tick();
    end
    reset_n = 1'b1; RegWriteW = 1'b0; clear_stats = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
